touch_sample_scheduler: RTL and testbench

Sequences the LT24 touchscreen driver into complete, filtered stroke points for the digit-drawing canvas. It enables the driver while armed and collects 2^AVG_LOG2 consecutive (x, y) conversions. It rejects noisy windows, averages the accepted window, scales it to 240x320 pixel coordinates and hands each point downstream over a valid/ready handshake. It also detects pen lift by timeout and flags the end of each stroke.

---
 rtl/touch_sample_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_touch_sample_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_sample_scheduler.sv
// touch_sample_scheduler: gathers windows of touch samples from the LT24 driver,
// rejects noisy windows, averages and scales accepted ones to 240x320 pixels and
// hands points downstream over valid/ready. Pen lift is detected by an ACQ timeout.
module touch_sample_scheduler #(
   parameter int unsigned AVG_LOG2      = 2,
   parameter int unsigned SPREAD_MAX    = 64,
   parameter int unsigned PENUP_TIMEOUT = 500000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        arm,
   output logic        drv_en,
   input  logic        drv_pos_ready,
   input  logic [11:0] drv_x_pos,
   input  logic [11:0] drv_y_pos,
   output logic        pt_valid,
   input  logic        pt_ready,
   output logic [7:0]  pt_x,
   output logic [8:0]  pt_y,
   output logic        stroke_end,
   output logic        reject
);

   localparam int unsigned SumW = 12 + AVG_LOG2;
   localparam int unsigned CntW = AVG_LOG2 + 1;
   localparam int unsigned TmoW = $clog2(PENUP_TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StAcq, StCheck, StScale, StOut} state_e;

   state_e          state_q, state_d;
   logic [SumW-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
   logic [11:0]     min_x_q, min_x_d, max_x_q, max_x_d;
   logic [11:0]     min_y_q, min_y_d, max_y_q, max_y_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            stroke_q, stroke_d;
   logic [7:0]      pt_x_q, pt_x_d;
   logic [8:0]      pt_y_q, pt_y_d;
   logic            clear_win;

   logic [11:0] avg_x, avg_y, spread_x, spread_y;
   logic [19:0] ax_ext, prod_x;
   // 4095 * 320 needs 21 bits; a 20-bit product would wrap for the bottom rows.
   logic [20:0] ay_ext, prod_y;
   logic        spread_bad, cnt_full, tmo_last;

   assign avg_x      = sum_x_q[SumW-1:AVG_LOG2];
   assign avg_y      = sum_y_q[SumW-1:AVG_LOG2];
   assign ax_ext     = {8'd0, avg_x};
   assign ay_ext     = {9'd0, avg_y};
   assign prod_x     = (ax_ext << 8) - (ax_ext << 4);
   assign prod_y     = (ay_ext << 8) + (ay_ext << 6);
   assign spread_x   = max_x_q - min_x_q;
   assign spread_y   = max_y_q - min_y_q;
   assign spread_bad = ({20'd0, spread_x} > SPREAD_MAX) || ({20'd0, spread_y} > SPREAD_MAX);
   assign cnt_full   = (cnt_q == CntW'(1 << AVG_LOG2));
   assign tmo_last   = (tmo_q == TmoW'(PENUP_TIMEOUT - 1));

   assign pt_x = pt_x_q;
   assign pt_y = pt_y_q;

   // Next-state, datapath updates and decoded outputs.
   always_comb begin
      state_d    = state_q;
      sum_x_d    = sum_x_q;
      sum_y_d    = sum_y_q;
      min_x_d    = min_x_q;
      max_x_d    = max_x_q;
      min_y_d    = min_y_q;
      max_y_d    = max_y_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      stroke_d   = stroke_q;
      pt_x_d     = pt_x_q;
      pt_y_d     = pt_y_q;
      clear_win  = 1'b0;
      drv_en     = 1'b1;
      pt_valid   = 1'b0;
      stroke_end = 1'b0;
      reject     = 1'b0;

      unique case (state_q)
         StIdle: begin
            drv_en    = 1'b0;
            clear_win = 1'b1;
            tmo_d     = '0;
            stroke_d  = 1'b0;
            if (arm) state_d = StAcq;
         end
         StAcq: begin
            if (!arm) begin
               state_d   = StIdle;
               clear_win = 1'b1;
               tmo_d     = '0;
               stroke_d  = 1'b0;
            end else if (cnt_full) begin
               // Window complete; further driver pulses are dropped from here on.
               state_d = StCheck;
            end else if (drv_pos_ready) begin
               sum_x_d = sum_x_q + SumW'(drv_x_pos);
               sum_y_d = sum_y_q + SumW'(drv_y_pos);
               if (cnt_q == '0) begin
                  min_x_d = drv_x_pos;
                  max_x_d = drv_x_pos;
                  min_y_d = drv_y_pos;
                  max_y_d = drv_y_pos;
               end else begin
                  if (drv_x_pos < min_x_q) min_x_d = drv_x_pos;
                  if (drv_x_pos > max_x_q) max_x_d = drv_x_pos;
                  if (drv_y_pos < min_y_q) min_y_d = drv_y_pos;
                  if (drv_y_pos > max_y_q) max_y_d = drv_y_pos;
               end
               cnt_d = cnt_q + CntW'(1);
               tmo_d = '0;
            end else if (tmo_last) begin
               clear_win = 1'b1;
               tmo_d     = '0;
               if (stroke_q) begin
                  stroke_end = 1'b1;
                  stroke_d   = 1'b0;
               end
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StCheck: begin
            if (!arm) begin
               state_d   = StIdle;
               clear_win = 1'b1;
               stroke_d  = 1'b0;
            end else if (spread_bad) begin
               reject    = 1'b1;
               clear_win = 1'b1;
               state_d   = StAcq;
            end else begin
               state_d = StScale;
            end
         end
         StScale: begin
            if (!arm) begin
               state_d   = StIdle;
               clear_win = 1'b1;
               stroke_d  = 1'b0;
            end else begin
               pt_x_d  = prod_x[19:12];
               pt_y_d  = prod_y[20:12];
               state_d = StOut;
            end
         end
         StOut: begin
            pt_valid = 1'b1;
            // A pending point always completes its handshake, even with arm low.
            if (pt_ready) begin
               stroke_d  = 1'b1;
               clear_win = 1'b1;
               state_d   = arm ? StAcq : StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (clear_win) begin
         sum_x_d = '0;
         sum_y_d = '0;
         min_x_d = '0;
         max_x_d = '0;
         min_y_d = '0;
         max_y_d = '0;
         cnt_d   = '0;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         sum_x_q  <= '0;
         sum_y_q  <= '0;
         min_x_q  <= '0;
         max_x_q  <= '0;
         min_y_q  <= '0;
         max_y_q  <= '0;
         cnt_q    <= '0;
         tmo_q    <= '0;
         stroke_q <= 1'b0;
         pt_x_q   <= '0;
         pt_y_q   <= '0;
      end else begin
         state_q  <= state_d;
         sum_x_q  <= sum_x_d;
         sum_y_q  <= sum_y_d;
         min_x_q  <= min_x_d;
         max_x_q  <= max_x_d;
         min_y_q  <= min_y_d;
         max_y_q  <= max_y_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         stroke_q <= stroke_d;
         pt_x_q   <= pt_x_d;
         pt_y_q   <= pt_y_d;
      end
   end

endmodule

// File: tb/tb_touch_sample_scheduler.sv
// Scoreboard bench for touch_sample_scheduler: stimulus pushes expected points,
// a negedge monitor pops and compares whenever the DUT presents a point.
module tb_touch_sample_scheduler;

   localparam int unsigned TMO    = 20;
   localparam int unsigned SPREAD = 64;

   logic        clk = 1'b0;
   logic        reset_n, arm, drv_en, drv_pos_ready, pt_valid, pt_ready;
   logic        stroke_end, reject;
   logic [11:0] drv_x_pos, drv_y_pos;
   logic [7:0]  pt_x;
   logic [8:0]  pt_y;

   touch_sample_scheduler #(
      .AVG_LOG2     (2),
      .SPREAD_MAX   (SPREAD),
      .PENUP_TIMEOUT(TMO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .arm          (arm),
      .drv_en       (drv_en),
      .drv_pos_ready(drv_pos_ready),
      .drv_x_pos    (drv_x_pos),
      .drv_y_pos    (drv_y_pos),
      .pt_valid     (pt_valid),
      .pt_ready     (pt_ready),
      .pt_x         (pt_x),
      .pt_y         (pt_y),
      .stroke_end   (stroke_end),
      .reject       (reject)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;
   int hs_cnt = 0, rej_cnt = 0, se_cnt = 0, exp_rej = 0;
   bit rej_prev = 1'b0, se_prev = 1'b0, last_point = 1'b0;
   int exp_px[$], exp_py[$], win_x[$], win_y[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented point against the scoreboard head.
   always @(negedge clk) begin
      if (pt_valid === 1'b1) begin
         if (exp_px.size() == 0) begin
            n_checks++;
            $display("FAIL pt_unexpected: point x=%0d y=%0d, expected none", pt_x, pt_y);
         end else begin
            check("pt_x", int'(pt_x), exp_px[0]);
            check("pt_y", int'(pt_y), exp_py[0]);
            if (pt_ready === 1'b1) begin
               void'(exp_px.pop_front());
               void'(exp_py.pop_front());
               hs_cnt++;
            end
         end
      end
      if (reject === 1'b1) begin
         rej_cnt++;
         if (rej_prev) check("reject_width", 2, 1);
      end
      if (stroke_end === 1'b1) begin
         se_cnt++;
         if (se_prev) check("stroke_end_width", 2, 1);
      end
      rej_prev = (reject === 1'b1);
      se_prev  = (stroke_end === 1'b1);
   end

   // Reference model: decide a full window from its spread, then average and scale.
   task automatic send_sample(input int x, input int y);
      int mnx, mxx, mny, mxy, sx, sy;
      drv_pos_ready = 1'b1;
      drv_x_pos     = 12'(x);
      drv_y_pos     = 12'(y);
      tick(1);
      drv_pos_ready = 1'b0;
      win_x.push_back(x);
      win_y.push_back(y);
      if (win_x.size() == 4) begin
         mnx = 4095; mxx = 0; mny = 4095; mxy = 0; sx = 0; sy = 0;
         for (int i = 0; i < 4; i++) begin
            if (win_x[i] < mnx) mnx = win_x[i];
            if (win_x[i] > mxx) mxx = win_x[i];
            if (win_y[i] < mny) mny = win_y[i];
            if (win_y[i] > mxy) mxy = win_y[i];
            sx += win_x[i];
            sy += win_y[i];
         end
         if ((mxx - mnx) > SPREAD || (mxy - mny) > SPREAD) begin
            exp_rej++;
            last_point = 1'b0;
         end else begin
            exp_px.push_back(((sx / 4) * 240) / 4096);
            exp_py.push_back(((sy / 4) * 320) / 4096);
            last_point = 1'b1;
         end
         win_x.delete();
         win_y.delete();
      end
   endtask

   task automatic send_win(input int xs[4], input int ys[4], input int gap_max);
      for (int i = 0; i < 4; i++) begin
         send_sample(xs[i], ys[i]);
         if (i < 3) tick($urandom_range(0, gap_max));
      end
   endtask

   task automatic wait_outcome(input bit rnd_ready);
      int h0, r0, i;
      h0 = hs_cnt;
      r0 = rej_cnt;
      i  = 0;
      while (hs_cnt == h0 && rej_cnt == r0 && i < 60) begin
         pt_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tick(1);
         i++;
      end
      pt_ready = 1'b1;
      if (last_point) begin
         check("outcome_point", hs_cnt - h0, 1);
         check("outcome_no_reject", rej_cnt - r0, 0);
      end else begin
         check("outcome_reject", rej_cnt - r0, 1);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      @(negedge clk);
      check({tag, "_drv_en"}, int'(drv_en), 0);
      check({tag, "_pt_valid"}, int'(pt_valid), 0);
      check({tag, "_stroke_end"}, int'(stroke_end), 0);
      check({tag, "_reject"}, int'(reject), 0);
      check({tag, "_pt_x"}, int'(pt_x), 0);
      check({tag, "_pt_y"}, int'(pt_y), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int i;
      i = 0;
      while (pt_valid !== 1'b1 && i < 20) begin
         tick(1);
         i++;
      end
      check(tag, int'(pt_valid === 1'b1), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int xs[4], ys[4];
      int se0, bad, bx, by, sel;
      bit noisy;
      reset_n = 1'b0; arm = 1'b0; drv_pos_ready = 1'b0; pt_ready = 1'b1;
      drv_x_pos = '0; drv_y_pos = '0;
      tick(3);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      tick(1);
      arm = 1'b1;
      @(negedge clk); check("drv_en_before_rise", int'(drv_en), 0);
      @(posedge clk); #1;
      @(negedge clk); check("drv_en_rise", int'(drv_en), 1);
      @(posedge clk); #1;

      // Mid-scale window with latency profile: valid only 3 edges after 4th sample.
      xs = '{12'hAAA, 12'hAAA, 12'hAAA, 12'hAAA};
      ys = '{12'h555, 12'h555, 12'h555, 12'h555};
      send_win(xs, ys, 0);
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("lat_valid_e%0d", i), int'(pt_valid), (i == 3) ? 1 : 0);
      end
      @(posedge clk); #1;

      xs = '{4095, 4095, 4095, 4095}; ys = '{4095, 4095, 4095, 4095};
      send_win(xs, ys, 1); wait_outcome(0);
      xs = '{0, 0, 0, 0}; ys = '{0, 0, 0, 0};
      send_win(xs, ys, 1); wait_outcome(0);

      // Noisy window: reject pulse in the cycle after the CHECK edge only.
      xs = '{1000, 1000, 1000, 1100}; ys = '{2000, 2000, 2000, 2000};
      send_win(xs, ys, 0);
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         check($sformatf("lat_reject_e%0d", i), int'(reject), (i == 1) ? 1 : 0);
      end
      @(posedge clk); #1;
      xs = '{1000, 1000, 1000, 1064};
      send_win(xs, ys, 1); wait_outcome(0);

      // Backpressure: point held while extra driver pulses arrive and are dropped.
      pt_ready = 1'b0;
      xs = '{2048, 2050, 2060, 2040}; ys = '{1500, 1510, 1490, 1505};
      send_win(xs, ys, 1);
      wait_valid("stall_valid_seen");
      for (int j = 0; j < 10; j++) begin
         drv_pos_ready = (j == 2 || j == 5);
         drv_x_pos     = 12'($urandom);
         drv_y_pos     = 12'($urandom);
         pt_ready      = 1'b0;
         tick(1);
      end
      drv_pos_ready = 1'b0;
      wait_outcome(0);
      xs = '{300, 310, 320, 330}; ys = '{700, 720, 710, 705};
      for (int i = 0; i < 3; i++) send_sample(xs[i], ys[i]);
      bad = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (pt_valid !== 1'b0) bad++;
      end
      check("partial_window_no_point", bad, 0);
      @(posedge clk); #1;
      send_sample(xs[3], ys[3]);
      wait_outcome(0);

      // Pen lift after an emitted point: exactly one stroke_end.
      se0 = se_cnt;
      tick(TMO + 5);
      check("stroke_end_once", se_cnt - se0, 1);
      tick(TMO + 5);
      check("stroke_end_no_repeat", se_cnt - se0, 1);

      // Arm drop mid-window discards it and clears the stroke flag silently.
      xs = '{900, 905, 910, 915}; ys = '{100, 110, 120, 130};
      send_win(xs, ys, 1); wait_outcome(0);
      send_sample(3000, 3000);
      send_sample(3010, 3010);
      arm = 1'b0;
      @(negedge clk); check("arm_drop_drv_en_pre", int'(drv_en), 1);
      @(posedge clk); #1;
      @(negedge clk); check("arm_drop_drv_en", int'(drv_en), 0);
      win_x.delete(); win_y.delete();
      @(posedge clk); #1;
      tick(3);
      arm = 1'b1;
      tick(1);
      se0 = se_cnt;
      tick(TMO + 5);
      check("idle_clears_stroke", se_cnt - se0, 0);
      xs = '{1234, 1240, 1250, 1260}; ys = '{2222, 2230, 2240, 2250};
      send_win(xs, ys, 1); wait_outcome(0);

      // Reset while a point is pending: point lost, outputs zero.
      pt_ready = 1'b0;
      xs = '{3500, 3510, 3520, 3530}; ys = '{3000, 3010, 3020, 3030};
      send_win(xs, ys, 1);
      wait_valid("rst_valid_seen");
      reset_n = 1'b0;
      @(posedge clk); #1;
      exp_px.delete(); exp_py.delete();
      check_outputs_zero("rst_pending");
      reset_n  = 1'b1;
      pt_ready = 1'b1;
      tick(2);

      // Randomized windows, mixing clean and noisy, with random backpressure.
      for (int w = 0; w < 30; w++) begin
         noisy = ($urandom_range(0, 3) == 0);
         sel   = $urandom_range(0, 7);
         bx    = $urandom_range(0, 3795);
         by    = $urandom_range(0, 3795);
         for (int s = 0; s < 4; s++) begin
            xs[s] = bx + $urandom_range(0, SPREAD);
            ys[s] = by + $urandom_range(0, SPREAD);
            if (noisy && s == sel % 4) begin
               if (sel < 4) xs[s] = bx + $urandom_range(SPREAD + 1, 300);
               else         ys[s] = by + $urandom_range(SPREAD + 1, 300);
            end
         end
         send_win(xs, ys, 2);
         wait_outcome(1);
      end

      tick(2);
      check("scoreboard_empty", exp_px.size(), 0);
      check("reject_total", rej_cnt, exp_rej);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
